hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Decodes the D-stage instruction and tracks E/M/W destination info in an internal shadow pipeline.
- Drives the select codes of the D/E/M forwarding muxes and the pipeline Stall.
- Sequences the multi-cycle mult/div unit with a busy counter.

---
 rtl/hazard_ctrl_pkg.sv | 101 ++++++++++
 rtl/hazard_ctrl_if.sv | 26 ++
 rtl/hazard_decode.sv | 98 +++++++++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the MIPS hazard/forwarding controller: opcodes, stage
// record layouts, forwarding select codes and the Tuse/Tnew timing helpers.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LINK  = 6'h3f;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [4:0] REG_RA = 5'd31;

  // Tuse: cycles until the operand is consumed, counted from D.
  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  // Tnew: cycles until the result exists, counted from entry into E.
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] FWD_D_RF     = 2'b00;
  localparam logic [1:0] FWD_D_ALU_M  = 2'b01;
  localparam logic [1:0] FWD_D_PC8_M  = 2'b10;

  localparam logic [1:0] FWD_RSE_RF    = 2'b00;
  localparam logic [1:0] FWD_RSE_ALU_M = 2'b01;
  localparam logic [1:0] FWD_RSE_W     = 2'b10;
  localparam logic [1:0] FWD_RTE_RF    = 2'b00;
  localparam logic [1:0] FWD_RTE_W     = 2'b01;
  localparam logic [1:0] FWD_RTE_ALU_M = 2'b10;
  localparam logic [1:0] FWD_E_PC8_M   = 2'b11;

  localparam logic [1:0] FWD_RTM_M = 2'b00;
  localparam logic [1:0] FWD_RTM_W = 2'b01;

  typedef enum logic [1:0] {
    KIND_ALU = 2'd0,
    KIND_DM  = 2'd1,
    KIND_PC8 = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_op_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    kind_e      kind;
    logic [1:0] tnew;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    md_op_e     md_op;
    logic       is_md;
  } dec_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    kind_e      kind;
    logic [1:0] tnew;
    md_op_e     md_op;
  } e_stage_t;

  // M keeps only what later checks read; rs and md_op are dead once past E.
  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] dest;
    kind_e      kind;
    logic [1:0] tnew;
  } m_stage_t;

  function automatic logic [1:0] tnew_step(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic raw_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dest, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dest) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if;
  // No valid/ready: IR_D is presented every cycle and every output is a pure
  // combinational function of IR_D and the controller's shadow state.
  logic [31:0] IR_D;
  logic        Stall;
  logic [1:0]  ForwardRSD;
  logic [1:0]  ForwardRTD;
  logic [1:0]  ForwardRSE;
  logic [1:0]  ForwardRTE;
  logic [1:0]  ForwardRTM;
  logic        MD_Start;
  logic        MD_Busy;

  modport master (
    output IR_D,
    input  Stall, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM,
    input  MD_Start, MD_Busy
  );

  modport slave (
    input  IR_D,
    output Stall, ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM,
    output MD_Start, MD_Busy
  );
endinterface

// File: rtl/hazard_decode.sv
// Combinational D-stage decode: register fields, destination, result kind and
// the Tuse/Tnew timing the hazard unit needs.
module hazard_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = ir_i[31:26];
  assign funct        = ir_i[5:0];
  assign rd           = ir_i[15:11];
  assign unused_shamt = ^ir_i[10:6];

  always_comb begin
    dec_o         = '0;
    dec_o.rs      = ir_i[25:21];
    dec_o.rt      = ir_i[20:16];
    dec_o.kind    = KIND_ALU;
    dec_o.md_op   = MD_NONE;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            dec_o.dest    = rd;
            dec_o.tnew    = TNEW_ALU;
            dec_o.use_rs  = 1'b1;
            dec_o.tuse_rs = TUSE_E;
            dec_o.use_rt  = 1'b1;
            dec_o.tuse_rt = TUSE_E;
          end
          FN_MULT, FN_DIV: begin
            dec_o.use_rs  = 1'b1;
            dec_o.tuse_rs = TUSE_E;
            dec_o.use_rt  = 1'b1;
            dec_o.tuse_rt = TUSE_E;
            dec_o.md_op   = (funct == FN_DIV) ? MD_DIV : MD_MULT;
            dec_o.is_md   = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            dec_o.dest    = rd;
            dec_o.tnew    = TNEW_ALU;
            dec_o.use_rs  = 1'b1;
            dec_o.tuse_rs = TUSE_E;
            dec_o.is_md   = 1'b1;
          end
          FN_JR: begin
            dec_o.use_rs  = 1'b1;
            dec_o.tuse_rs = TUSE_D;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_LUI: begin
        dec_o.dest    = ir_i[20:16];
        dec_o.tnew    = TNEW_ALU;
        dec_o.use_rs  = 1'b1;
        dec_o.tuse_rs = TUSE_E;
      end
      OP_LW: begin
        dec_o.dest    = ir_i[20:16];
        dec_o.kind    = KIND_DM;
        dec_o.tnew    = TNEW_LOAD;
        dec_o.use_rs  = 1'b1;
        dec_o.tuse_rs = TUSE_E;
      end
      OP_SW: begin
        dec_o.use_rs  = 1'b1;
        dec_o.tuse_rs = TUSE_E;
        dec_o.use_rt  = 1'b1;
        dec_o.tuse_rt = TUSE_M;
      end
      OP_BEQ: begin
        dec_o.use_rs  = 1'b1;
        dec_o.tuse_rs = TUSE_D;
        dec_o.use_rt  = 1'b1;
        dec_o.tuse_rt = TUSE_D;
      end
      OP_JAL: begin
        dec_o.dest = REG_RA;
        dec_o.kind = KIND_PC8;
        dec_o.tnew = TNEW_ALU;
      end
      OP_LINK: begin
        dec_o.dest = ir_i[20:16];
        dec_o.kind = KIND_PC8;
        dec_o.tnew = TNEW_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: shadows the
// E/M/W destinations, raises Stall, picks forwarding sources, times mult/div.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz_if
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  dec_t             dec;
  e_stage_t         e_q, e_d;
  m_stage_t         m_q, m_d;
  logic [4:0]       w_dest_q, w_dest_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             stall;
  logic             md_start;
  logic             md_busy;

  hazard_decode u_decode (
    .ir_i  (hz_if.IR_D),
    .dec_o (dec)
  );

  assign md_start = (e_q.md_op != MD_NONE);
  assign md_busy  = (md_cnt_q != '0);

  always_comb begin
    stall = 1'b0;
    if (dec.use_rs && (raw_hazard(dec.rs, dec.tuse_rs, e_q.dest, e_q.tnew) ||
                       raw_hazard(dec.rs, dec.tuse_rs, m_q.dest, m_q.tnew)))
      stall = 1'b1;
    if (dec.use_rt && (raw_hazard(dec.rt, dec.tuse_rt, e_q.dest, e_q.tnew) ||
                       raw_hazard(dec.rt, dec.tuse_rt, m_q.dest, m_q.tnew)))
      stall = 1'b1;
    // HI/LO readers and new mult/div wait until the unit drains.
    if (dec.is_md && (md_start || md_busy))
      stall = 1'b1;
  end

  // A stalled D instruction leaves a bubble in E; M and W always advance.
  // Every producer reaches W with Tnew 0, so W only needs its destination.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs    = dec.rs;
      e_d.rt    = dec.rt;
      e_d.dest  = dec.dest;
      e_d.kind  = dec.kind;
      e_d.tnew  = dec.tnew;
      e_d.md_op = dec.md_op;
    end
    m_d.rt   = e_q.rt;
    m_d.dest = e_q.dest;
    m_d.kind = e_q.kind;
    m_d.tnew = tnew_step(e_q.tnew);
    w_dest_d = m_q.dest;
  end

  always_comb begin
    md_cnt_d = '0;
    if (md_start)
      md_cnt_d = (e_q.md_op == MD_DIV) ? DIV_LOAD : MULT_LOAD;
    else if (md_busy)
      md_cnt_d = md_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q      <= '0;
      m_q      <= '0;
      w_dest_q <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_dest_q <= w_dest_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  function automatic logic [1:0] fwd_d_code(input logic [4:0] src, input m_stage_t m);
    if (src != 5'd0 && src == m.dest && m.tnew == 2'd0) begin
      if (m.kind == KIND_PC8) return FWD_D_PC8_M;
      if (m.kind == KIND_ALU) return FWD_D_ALU_M;
    end
    return FWD_D_RF;
  endfunction

  // A ready M result beats W; a load still in M falls through to the W check.
  function automatic logic [1:0] fwd_e_code(input logic [4:0] src, input m_stage_t m,
                                            input logic [4:0] w_dest,
                                            input logic [1:0] code_alu,
                                            input logic [1:0] code_w);
    if (src != 5'd0 && src == m.dest && m.tnew == 2'd0) begin
      if (m.kind == KIND_PC8) return FWD_E_PC8_M;
      if (m.kind == KIND_ALU) return code_alu;
    end
    if (src != 5'd0 && src == w_dest) return code_w;
    return 2'b00;
  endfunction

  assign hz_if.Stall      = stall;
  assign hz_if.ForwardRSD = fwd_d_code(dec.rs, m_q);
  assign hz_if.ForwardRTD = fwd_d_code(dec.rt, m_q);
  assign hz_if.ForwardRSE = fwd_e_code(e_q.rs, m_q, w_dest_q, FWD_RSE_ALU_M, FWD_RSE_W);
  assign hz_if.ForwardRTE = fwd_e_code(e_q.rt, m_q, w_dest_q, FWD_RTE_ALU_M, FWD_RTE_W);
  assign hz_if.ForwardRTM = (m_q.rt != 5'd0 && m_q.rt == w_dest_q) ? FWD_RTM_W : FWD_RTM_M;
  assign hz_if.MD_Start   = md_start;
  assign hz_if.MD_Busy    = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl: one row per D-stage cycle with
// hand-derived outputs, plus a hand-written asynchronous-reset sequence.
module tb_hazard_ctrl;

  typedef struct {
    logic [31:0] ir;
    logic [12:0] exp;
    string       nm;
  } vec_t;

  // Expected word layout: {Stall, RSD, RTD, RSE, RTE, RTM, MD_Start, MD_Busy}
  localparam logic [12:0] Z       = 13'h0000;
  localparam logic [12:0] STALL   = 13'h1000;
  localparam logic [12:0] RSD_ALU = 13'h0400;
  localparam logic [12:0] RSD_PC8 = 13'h0800;
  localparam logic [12:0] RTD_ALU = 13'h0100;
  localparam logic [12:0] RSE_ALU = 13'h0040;
  localparam logic [12:0] RSE_W   = 13'h0080;
  localparam logic [12:0] RSE_PC8 = 13'h00c0;
  localparam logic [12:0] RTE_W   = 13'h0010;
  localparam logic [12:0] RTE_ALU = 13'h0020;
  localparam logic [12:0] RTM_W   = 13'h0004;
  localparam logic [12:0] MSTART  = 13'h0002;
  localparam logic [12:0] MBUSY   = 13'h0001;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic [12:0] exp_q[$];
  vec_t        vecs[$];

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz_if   (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] addu(input int rd, input int rs, input int rt);
    return r_op(rs, rt, rd, 6'h21);
  endfunction
  function automatic logic [31:0] subu(input int rd, input int rs, input int rt);
    return r_op(rs, rt, rd, 6'h23);
  endfunction
  function automatic logic [31:0] mult(input int rs, input int rt);
    return r_op(rs, rt, 0, 6'h18);
  endfunction
  function automatic logic [31:0] div(input int rs, input int rt);
    return r_op(rs, rt, 0, 6'h1a);
  endfunction
  function automatic logic [31:0] mfhi(input int rd);
    return r_op(0, 0, rd, 6'h10);
  endfunction
  function automatic logic [31:0] mflo(input int rd);
    return r_op(0, 0, rd, 6'h12);
  endfunction
  function automatic logic [31:0] jr(input int rs);
    return r_op(rs, 0, 0, 6'h08);
  endfunction
  function automatic logic [31:0] ori(input int rt, input int rs, input int imm);
    return i_op(6'h0d, rs, rt, imm);
  endfunction
  function automatic logic [31:0] lw(input int rt, input int base, input int imm);
    return i_op(6'h23, base, rt, imm);
  endfunction
  function automatic logic [31:0] sw(input int rt, input int base, input int imm);
    return i_op(6'h2b, base, rt, imm);
  endfunction
  function automatic logic [31:0] beq(input int rs, input int rt);
    return i_op(6'h04, rs, rt, 4);
  endfunction
  function automatic logic [31:0] link(input int rt);
    return i_op(6'h3f, 0, rt, 0);
  endfunction
  function automatic logic [31:0] jal();
    return {6'h03, 26'h0000010};
  endfunction

  task automatic add(input logic [31:0] ir, input string nm, input logic [12:0] e);
    vec_t v;
    v.ir  = ir;
    v.nm  = nm;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic add_flush();
    for (int k = 0; k < 3; k++) add(32'h0, "flush", Z);
  endtask

  task automatic check(input string nm);
    logic [12:0] act;
    logic [12:0] exp;
    act = {hz_if.Stall, hz_if.ForwardRSD, hz_if.ForwardRTD, hz_if.ForwardRSE,
           hz_if.ForwardRTE, hz_if.ForwardRTM, hz_if.MD_Start, hz_if.MD_Busy};
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (Stall,RSD,RTD,RSE,RTE,RTM,Start,Busy)", nm, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] ir, input logic [12:0] e, input string nm);
    @(negedge clk);
    hz_if.IR_D = ir;
    #1;
    exp_q.push_back(e);
    check(nm);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // load-use: one bubble, then both operands from W
    add(lw(8, 0, 0),     "lu_lw",       Z);
    add(addu(9, 8, 8),   "lu_stall",    STALL);
    add(addu(9, 8, 8),   "lu_release",  Z);
    add(32'h0,           "lu_fwd_w",    RSE_W | RTE_W);
    add(32'h0,           "lu_tail1",    Z);
    add(32'h0,           "lu_tail2",    Z);
    // ALU result into a branch: stall while in E, forward from M to D
    add(addu(3, 1, 2),   "br_addu",     Z);
    add(beq(3, 0),       "br_stall",    STALL);
    add(beq(3, 0),       "br_fwd_d",    RSD_ALU);
    add(32'h0,           "br_e_from_w", RSE_W);
    add(32'h0,           "br_tail1",    Z);
    add(32'h0,           "br_tail2",    Z);
    // jal then jr $31
    add(jal(),           "jr_jal",      Z);
    add(jr(31),          "jr_stall",    STALL);
    add(jr(31),          "jr_fwd_pc8",  RSD_PC8);
    add(32'h0,           "jr_e_from_w", RSE_W);
    add(32'h0,           "jr_tail1",    Z);
    add(32'h0,           "jr_tail2",    Z);
    // jal directly followed by an ALU reader of $31: PC+8 from M into E
    add(jal(),           "ja_jal",      Z);
    add(addu(4, 31, 0),  "ja_nostall",  Z);
    add(32'h0,           "ja_e_pc8",    RSE_PC8);
    add_flush();
    // jal; nop; addu: reader sees jal in M from D, then in W from E
    add(jal(),           "jna_jal",     Z);
    add(32'h0,           "jna_nop",     Z);
    add(addu(4, 31, 0),  "jna_d_pc8",   RSD_PC8);
    add(32'h0,           "jna_e_w",     RSE_W);
    add(32'h0,           "jna_tail1",   Z);
    add(32'h0,           "jna_tail2",   Z);
    // load feeding store data: no stall, store data from W once sw is in M
    add(lw(5, 0, 0),     "ls_lw",       Z);
    add(sw(5, 0, 4),     "ls_nostall",  Z);
    add(32'h0,           "ls_e_none",   Z);
    add(32'h0,           "ls_rtm_w",    RTM_W);
    add(32'h0,           "ls_tail",     Z);
    // mult; mflo: start one cycle, busy five, reader held throughout
    add(mult(1, 2),      "mul_issue",   Z);
    add(mflo(6),         "mul_start",   STALL | MSTART);
    for (int k = 0; k < 5; k++) add(mflo(6), "mul_busy", STALL | MBUSY);
    add(mflo(6),         "mul_done",    Z);
    add_flush();
    // div; mfhi: busy window of ten
    add(div(1, 2),       "div_issue",   Z);
    add(mfhi(7),         "div_start",   STALL | MSTART);
    for (int k = 0; k < 10; k++) add(mfhi(7), "div_busy", STALL | MBUSY);
    add(mfhi(7),         "div_done",    Z);
    add_flush();
    // stall and E forwarding in the same cycle
    add(ori(7, 0, 1),    "sf_ori",      Z);
    add(lw(8, 7, 0),     "sf_lw",       Z);
    add(addu(9, 8, 8),   "sf_both",     STALL | RSE_ALU);
    add(addu(9, 8, 8),   "sf_release",  Z);
    add(32'h0,           "sf_fwd_w",    RSE_W | RTE_W);
    add(32'h0,           "sf_tail1",    Z);
    add(32'h0,           "sf_tail2",    Z);
    // M and W both hold $3: M wins in E; later M-store-data style match
    add(addu(3, 1, 2),   "mw_first",    Z);
    add(subu(3, 1, 2),   "mw_second",   Z);
    add(addu(4, 3, 3),   "mw_d_fwd",    RSD_ALU | RTD_ALU);
    add(32'h0,           "mw_m_wins",   RSE_ALU | RTE_ALU);
    add(32'h0,           "mw_rtm",      RTM_W);
    add(32'h0,           "mw_tail",     Z);
    // load still in M blocks a branch (Tnew_M 1 > Tuse 0)
    add(lw(8, 0, 0),     "lb_lw",       Z);
    add(32'h0,           "lb_nop",      Z);
    add(beq(8, 0),       "lb_stall_m",  STALL);
    add(beq(8, 0),       "lb_release",  Z);
    add_flush();
    // LINK writes PC+8 to rt
    add(link(10),        "lk_link",     Z);
    add(addu(11, 10, 0), "lk_nostall",  Z);
    add(32'h0,           "lk_e_pc8",    RSE_PC8);
    add_flush();
    // $0 producer is never a hazard nor a forwarding source
    add(addu(0, 1, 2),   "z_prod",      Z);
    add(beq(0, 0),       "z_nostall",   Z);
    add(addu(4, 0, 0),   "z_no_d",      Z);
    add(32'h0,           "z_no_e",      Z);
    add(32'h0,           "z_tail1",     Z);
    add(32'h0,           "z_tail2",     Z);

    reset_n    = 1'b0;
    hz_if.IR_D = mflo(6);
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back(Z);
    check("reset_state");
    @(negedge clk);
    hz_if.IR_D = 32'h0;
    reset_n    = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].ir, vecs[i].exp, $sformatf("%0d:%s", i, vecs[i].nm));

    // asynchronous reset while the mult/div unit is busy
    step(addu(3, 1, 2), Z,               "rm_addu");
    step(mult(1, 2),    Z,               "rm_mult");
    step(mflo(6),       STALL | MSTART,  "rm_start");
    step(mflo(6),       STALL | MBUSY,   "rm_busy");
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(Z);
    check("rm_in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    hz_if.IR_D = addu(4, 3, 3);
    #1;
    exp_q.push_back(Z);
    check("rm_after_d");
    step(32'h0, Z, "rm_after_e");
    step(32'h0, Z, "rm_after_m");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
